line_card_read_scheduler: RTL and testbench
===========================================

LINE_CARD_READ_SCHEDULER -- requirements
Module: line_card_read_scheduler

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 24, number of ingress FIFOs sharing the cascaded read port.
REQ-002 SHALL have parameter PTR_BITS, default 13, width of each per-port FIFO pointer (12-bit word address plus wrap bit).
REQ-003 SHALL have parameter TIMEOUT, default 4096, maximum cycles allowed in WAIT_DONE.
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 SHALL have port clk  input  1  fabric clock; all logic on its rising edge.
REQ-006 SHALL have port areset_n  input  1  asynchronous active-low reset.
REQ-007 SHALL have port wr_ptr_committed  input  NUM_PORTS x PTR_BITS  per-port committed write pointer.
REQ-008 SHALL have port port_reset  input  NUM_PORTS  per-port synchronous FIFO reset (from CDC reset state).
REQ-009 SHALL have port rd_ptr  output  NUM_PORTS x PTR_BITS  per-port read pointer, fed back to each ingress FIFO.
REQ-010 SHALL have port grant_valid  output  1  a port is granted the shared read port.
REQ-011 SHALL have port grant_port  output  5  index of the granted port.
REQ-012 SHALL have port grant_ptr  output  PTR_BITS  start read pointer of the granted frame.
REQ-013 SHALL have port grant_ready  input  1  frame reader accepts the grant.
REQ-014 SHALL have port done_valid  input  1  single-cycle pulse: frame reader finished the frame.
REQ-015 SHALL have port done_ptr  input  PTR_BITS  read pointer just past the finished frame.
REQ-016 SHALL have port timeout_err  output  1  single-cycle pulse on watchdog expiry.

Function
REQ-017 SHALL define pending[p] = (wr_ptr_committed[p] != rd_ptr[p]) && !port_reset[p], full-width compare, so pointer wrap needs no special case.
REQ-018 SHALL implement states IDLE, GRANT, WAIT_DONE.
REQ-019 IDLE: SHALL pick the first p with pending[p], searching upward from rr_next and wrapping at NUM_PORTS-1 to 0; if found, load grant_port=p, grant_ptr=rd_ptr[p] and enter GRANT next cycle; else stay IDLE.
REQ-020 Latency: pending asserted in cycle N while IDLE SHALL give grant_valid=1 in cycle N+1.
REQ-021 GRANT: grant_valid SHALL be 1, with grant_port/grant_ptr held stable until grant_valid && grant_ready, then enter WAIT_DONE.
REQ-022 WAIT_DONE: on done_valid, SHALL write rd_ptr[grant_port] <= done_ptr, set rr_next <= (grant_port+1) mod NUM_PORTS and return to IDLE.
REQ-023 done_valid outside WAIT_DONE SHALL be ignored.
REQ-024 WAIT_DONE SHALL count cycles from 0; at TIMEOUT-1 without done_valid it SHALL set rd_ptr[grant_port] <= wr_ptr_committed[grant_port] (flush), pulse timeout_err for 1 cycle, advance rr_next as in REQ-022 and return to IDLE.
REQ-025 port_reset[p] SHALL force rd_ptr[p] <= 0 every cycle asserted, overriding REQ-022 and REQ-024.
REQ-026 If port_reset[grant_port] is asserted in GRANT, SHALL deassert grant_valid next cycle and return to IDLE with rr_next unchanged.
REQ-027 If port_reset[grant_port] is asserted in WAIT_DONE, SHALL stay in WAIT_DONE; the subsequent done_ptr is discarded and rd_ptr stays 0.
REQ-028 At most one grant SHALL be outstanding at any time.
REQ-029 A single port with continuous pending SHALL not be granted twice in a row while another port is pending.

Reset
REQ-030 While areset_n=0: state=IDLE, rr_next=0, all rd_ptr=0, grant_valid=0, grant_port=0, grant_ptr=0, timeout_err=0, watchdog counter=0.
REQ-031 The first grant SHALL be possible in the cycle after areset_n deasserts plus one (per REQ-020).

Verification
REQ-032 Only port 3 with wr_ptr_committed=0x040 after reset -> grant_port=3, grant_ptr=0 one cycle later; done_ptr=0x040 -> rd_ptr[3]=0x040, then no grant.
REQ-033 Ports 0, 5 and 23 pending continuously, immediate ready/done -> grant order 0,5,23,0,5,23.
REQ-034 rd_ptr[7]=0x1FF0, wr_ptr_committed[7]=0x0010 (wrap) -> port 7 granted with grant_ptr=0x1FF0.
REQ-035 Grant to port 2 held with grant_ready=0, port_reset[2] pulsed -> grant_valid=0 next cycle, rd_ptr[2]=0, state IDLE.
REQ-036 Port 9 granted, no done_valid for 4096 cycles -> timeout_err pulses once, rd_ptr[9]=wr_ptr_committed[9], next grant search starts at port 10.

Source files
------------

// File: rtl/line_card_read_scheduler.sv
// line_card_read_scheduler: round-robin arbiter granting ingress FIFOs a shared cascaded read port
module line_card_read_scheduler #(
  parameter int NUM_PORTS = 24,
  parameter int PTR_BITS  = 13,
  parameter int TIMEOUT   = 4096
) (
  input  logic                               clk,
  input  logic                               areset_n,
  input  logic [NUM_PORTS-1:0][PTR_BITS-1:0] wr_ptr_committed,
  input  logic [NUM_PORTS-1:0]               port_reset,
  output logic [NUM_PORTS-1:0][PTR_BITS-1:0] rd_ptr,
  output logic                               grant_valid,
  output logic [4:0]                         grant_port,
  output logic [PTR_BITS-1:0]                grant_ptr,
  input  logic                               grant_ready,
  input  logic                               done_valid,
  input  logic [PTR_BITS-1:0]                done_ptr,
  output logic                               timeout_err
);
  typedef enum logic [1:0] {IDLE, GRANT, WAIT_DONE} state_e;
  localparam int CW = $clog2(TIMEOUT + 1);
  state_e                             state_q, state_d;
  logic [4:0]                         rr_q, rr_d, gp_q, gp_d, sel, rr_adv;
  logic [PTR_BITS-1:0]                gptr_q, gptr_d, wr_val;
  logic [NUM_PORTS-1:0][PTR_BITS-1:0] rd_q;
  logic [NUM_PORTS-1:0]               pend;
  logic [CW-1:0]                      cnt_q, cnt_d;
  logic                               found, wr_en, tout_q, tout_d, disc_q, disc_d, gp_rst, expire;
  int                                 j;

  assign rd_ptr      = rd_q;
  assign grant_valid = state_q == GRANT;
  assign grant_port  = gp_q;
  assign grant_ptr   = gptr_q;
  assign timeout_err = tout_q;
  assign gp_rst      = port_reset[gp_q];
  assign expire      = cnt_q == CW'(TIMEOUT - 1);
  assign rr_adv      = gp_q == 5'(NUM_PORTS - 1) ? 5'd0 : gp_q + 5'd1;

  // Full-width pointer compare makes wrap-around free; ports in reset never request
  always_comb begin
    for (int p = 0; p < NUM_PORTS; p++) pend[p] = wr_ptr_committed[p] != rd_q[p] && !port_reset[p];
  end

  // First pending port at or above rr_q, wrapping back to port 0
  always_comb begin
    found = 1'b0;
    sel   = '0;
    j     = 0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      j = int'(rr_q) + i;
      j = j >= NUM_PORTS ? j - NUM_PORTS : j;
      if (!found && pend[j]) begin
        found = 1'b1;
        sel   = 5'(j);
      end
    end
  end

  // Next-state logic: grant handshake, completion, watchdog flush and reset-during-frame discard
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    gp_d    = gp_q;
    gptr_d  = gptr_q;
    cnt_d   = cnt_q;
    disc_d  = disc_q;
    wr_en   = 1'b0;
    wr_val  = done_ptr;
    tout_d  = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        gp_d    = sel;
        gptr_d  = rd_q[sel];
      end
      GRANT: if (gp_rst) state_d = IDLE;
        else if (grant_ready) begin
          state_d = WAIT_DONE;
          cnt_d   = '0;
          disc_d  = 1'b0;
        end
      WAIT_DONE: begin
        cnt_d  = cnt_q + CW'(1);
        disc_d = disc_q | gp_rst;
        if (done_valid || expire) begin
          state_d = IDLE;
          rr_d    = rr_adv;
          wr_en   = !(disc_q || gp_rst);
          wr_val  = done_valid ? done_ptr : wr_ptr_committed[gp_q];
          tout_d  = !done_valid;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and grant registers
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      state_q <= IDLE;
      rr_q    <= '0;
      gp_q    <= '0;
      gptr_q  <= '0;
      cnt_q   <= '0;
      disc_q  <= 1'b0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      gp_q    <= gp_d;
      gptr_q  <= gptr_d;
      cnt_q   <= cnt_d;
      disc_q  <= disc_d;
      tout_q  <= tout_d;
    end
  end

  // Per-port read pointers; a port's own reset beats any completion or flush write
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) rd_q <= '0;
    else for (int p = 0; p < NUM_PORTS; p++)
      rd_q[p] <= port_reset[p] ? '0 : (wr_en && gp_q == 5'(p)) ? wr_val : rd_q[p];
  end
endmodule

// File: tb/tb_line_card_read_scheduler.sv
// tb_line_card_read_scheduler: directed vector bench for the read scheduler
module tb_line_card_read_scheduler;
  typedef struct {
    logic [23:0] pend;
    logic [12:0] dp;
    logic [4:0]  port;
    logic [12:0] ptr;
  } vec_t;

  logic              clk = 1'b0;
  logic              areset_n;
  logic [23:0][12:0] wr;
  logic [23:0]       prst;
  logic [23:0][12:0] rd;
  logic              gv, gr, dv, te;
  logic [4:0]        gp;
  logic [12:0]       gptr, dptr;
  int                checks = 0, failures = 0;
  vec_t              vecs[12];

  line_card_read_scheduler dut (
    .clk(clk), .areset_n(areset_n), .wr_ptr_committed(wr), .port_reset(prst),
    .rd_ptr(rd), .grant_valid(gv), .grant_port(gp), .grant_ptr(gptr),
    .grant_ready(gr), .done_valid(dv), .done_ptr(dptr), .timeout_err(te)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_grant(input string nm, input logic [4:0] ep, input logic [12:0] eptr);
    int n = 0;
    do begin
      tick();
      n++;
    end while (!gv && n < 20);
    chk({nm, "_lat"}, n, 1);
    chk({nm, "_port"}, gp, ep);
    chk({nm, "_ptr"}, gptr, eptr);
  endtask

  task automatic accept_done(input logic [12:0] dp);
    gr = 1'b1;
    tick();
    gr = 1'b0;
    dv = 1'b1;
    dptr = dp;
    tick();
    dv = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    vecs[0]  = '{24'h800021, 13'h011, 5'd0,  13'h000};
    vecs[1]  = '{24'h800021, 13'h055, 5'd5,  13'h000};
    vecs[2]  = '{24'h800021, 13'h077, 5'd23, 13'h000};
    vecs[3]  = '{24'h800021, 13'h012, 5'd0,  13'h011};
    vecs[4]  = '{24'h800021, 13'h056, 5'd5,  13'h055};
    vecs[5]  = '{24'h800021, 13'h078, 5'd23, 13'h077};
    vecs[6]  = '{24'h000060, 13'h0AA, 5'd5,  13'h056};
    vecs[7]  = '{24'h000060, 13'h0BB, 5'd6,  13'h000};
    vecs[8]  = '{24'h000060, 13'h0AB, 5'd5,  13'h0AA};
    vecs[9]  = '{24'h800002, 13'h0CC, 5'd23, 13'h000};
    vecs[10] = '{24'h800002, 13'h0DD, 5'd1,  13'h000};
    vecs[11] = '{24'h800002, 13'h0CD, 5'd23, 13'h0CC};
    areset_n = 1'b0;
    wr = '0;
    wr[3] = 13'h040;
    prst = '0;
    gr = 1'b0;
    dv = 1'b0;
    dptr = '0;
    repeat (3) tick();
    chk("rst_gv", gv, 0);
    chk("rst_gp", gp, 0);
    chk("rst_gptr", gptr, 0);
    chk("rst_te", te, 0);
    chk("rst_rd3", rd[3], 0);
    areset_n = 1'b1;
    expect_grant("p3", 5'd3, 13'h000);
    accept_done(13'h040);
    chk("p3_rd", rd[3], 13'h040);
    repeat (3) tick();
    chk("p3_idle", gv, 0);
    dv = 1'b1;
    dptr = 13'h777;
    tick();
    dv = 1'b0;
    chk("stray_done_rd", rd[3], 13'h040);
    chk("stray_done_gv", gv, 0);
    areset_n = 1'b0;
    tick();
    chk("rst2_rd3", rd[3], 0);
    for (int p = 0; p < 24; p++) wr[p] = 13'hABC;
    areset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      prst = ~vecs[i].pend;
      expect_grant($sformatf("v%0d", i), vecs[i].port, vecs[i].ptr);
      accept_done(vecs[i].dp);
      chk($sformatf("v%0d_rd", i), rd[vecs[i].port], vecs[i].dp);
    end
    prst = ~(24'd1 << 7);
    wr[7] = 13'h1FF0;
    expect_grant("w7a", 5'd7, 13'h000);
    accept_done(13'h1FF0);
    chk("w7a_rd", rd[7], 13'h1FF0);
    wr[7] = 13'h0010;
    expect_grant("w7b", 5'd7, 13'h1FF0);
    accept_done(13'h0010);
    repeat (2) tick();
    chk("w7_idle", gv, 0);
    prst = ~(24'd1 << 2);
    expect_grant("h2a", 5'd2, 13'h000);
    accept_done(13'h123);
    expect_grant("h2b", 5'd2, 13'h123);
    dv = 1'b1;
    dptr = 13'h777;
    tick();
    dv = 1'b0;
    chk("hold_gv", gv, 1);
    chk("hold_gp", gp, 2);
    chk("hold_gptr", gptr, 13'h123);
    prst[2] = 1'b1;
    tick();
    prst[2] = 1'b0;
    chk("abort_gv", gv, 0);
    chk("abort_rd2", rd[2], 0);
    expect_grant("h2c", 5'd2, 13'h000);
    gr = 1'b1;
    tick();
    gr = 1'b0;
    prst[2] = 1'b1;
    tick();
    prst[2] = 1'b0;
    chk("wd_rst_rd2", rd[2], 0);
    chk("wd_rst_gv", gv, 0);
    dv = 1'b1;
    dptr = 13'h555;
    tick();
    dv = 1'b0;
    chk("discard_rd2", rd[2], 0);
    prst = '1;
    tick();
    chk("discard_idle", gv, 0);
    for (int p = 0; p < 24; p++) wr[p] = 13'h321;
    prst = ~(24'd1 << 9);
    expect_grant("t9", 5'd9, 13'h000);
    gr = 1'b1;
    tick();
    gr = 1'b0;
    n = 0;
    while (n < 5000 && !te) begin
      tick();
      n++;
    end
    chk("to_cycles", n, 4096);
    chk("to_rd9", rd[9], 13'h321);
    chk("to_gv", gv, 0);
    wr[9] = 13'h322;
    prst = ~((24'd1 << 4) | (24'd1 << 9) | (24'd1 << 12));
    tick();
    chk("to_pulse", te, 0);
    chk("to_next_gv", gv, 1);
    chk("to_next_gp", gp, 12);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
